// File: rtl/int_ctrl.sv
// -----------------------------------------------------------------------------
// int_ctrl -- hardware interrupt front end for the CP0 register block.
//
// Six asynchronous external interrupt lines are optionally inverted,
// synchronised through a two-flop chain and glitch-filtered. Each line then
// drives its bit of int_o in one of two modes:
//   level mode: int_o follows the filtered level, one register stage later;
//   edge mode : a filtered rising edge sets a pending bit that stays set
//               until software clears it with a one-cycle acknowledge.
// The result feeds CP0 int_i, which is latched into cause[15:10].
//
// Optional feature, selected by the macro TIMER_INT_MERGE_EN:
//   defined   : int_o[5] = pending[5] | timer_int_i (combinational, no ack)
//   undefined : int_o[5] = pending[5]; timer_int_i is accepted but unused
//
// Parameters:
//   FILTER_CYCLES  consecutive cycles a synchronised line must disagree with
//                  its filtered value before the filtered value follows it;
//                  0 bypasses the filter completely
//   INV_MASK       per-line inversion ahead of the synchroniser
//                  (1 = the line is active-low at the pin)
//
// Ports:
//   cpu_clk_50M   in   1  system clock
//   cpu_rst_n     in   1  synchronous, active-low reset
//   ext_int_i     in   6  asynchronous external interrupt lines
//   edge_mode_i   in   6  per line: 1 = rising-edge/pending, 0 = level
//   int_ack_i     in   6  per-line one-cycle clear of the pending bit
//   timer_int_i   in   1  timer interrupt from CP0
//   int_o         out  6  interrupt vector to CP0 int_i
//
// Latency: an input change set up before edge E0 appears on int_o after edge
// E(FILTER_CYCLES+2), in both level and edge mode.
// -----------------------------------------------------------------------------
module int_ctrl #(
    parameter int unsigned FILTER_CYCLES = 2,
    parameter logic [5:0]  INV_MASK      = 6'b000000
) (
    input  logic       cpu_clk_50M,
    input  logic       cpu_rst_n,
    input  logic [5:0] ext_int_i,
    input  logic [5:0] edge_mode_i,
    input  logic [5:0] int_ack_i,
    input  logic       timer_int_i,
    output logic [5:0] int_o
);

    // -------------------------------------------------------------------------
    // Input conditioning and two-flop synchroniser
    // -------------------------------------------------------------------------
    logic [5:0] x_cond;
    logic [5:0] sync1_reg;
    logic [5:0] sync2_reg;

    // Inversion happens before the first flop so every later stage sees
    // active-high lines regardless of pin polarity.
    assign x_cond = ext_int_i ^ INV_MASK;

    always_ff @(posedge cpu_clk_50M) begin
        if (!cpu_rst_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= x_cond;
            sync2_reg <= sync1_reg;
        end
    end

    // Per-line results gathered back into vectors.
    logic [5:0] filt;
    logic [5:0] pending_vec;

    // -------------------------------------------------------------------------
    // Per-line glitch filter, edge detector and pending logic
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_line

            if (FILTER_CYCLES == 0) begin : g_nofilt
                // Filter bypassed: the filtered level is the synchronised one.
                assign filt[gi] = sync2_reg[gi];
            end else begin : g_filt
                localparam int unsigned CNT_W = $clog2(FILTER_CYCLES + 1);
                localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

                logic [CNT_W-1:0] cnt_reg;
                logic [CNT_W-1:0] cnt_next;
                logic             filt_reg;
                logic             filt_next;

                // cnt counts how many consecutive earlier cycles the
                // synchronised line already disagreed with filt. When the
                // current cycle disagrees as well and that count has reached
                // FILTER_CYCLES-1, the disagreement has lasted FILTER_CYCLES
                // cycles and filt takes the new value. Any agreement restarts
                // the count, so shorter glitches never reach filt.
                always_comb begin
                    cnt_next  = cnt_reg;
                    filt_next = filt_reg;
                    if (sync2_reg[gi] == filt_reg) begin
                        cnt_next = '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        filt_next = sync2_reg[gi];
                        cnt_next  = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end

                always_ff @(posedge cpu_clk_50M) begin
                    if (!cpu_rst_n) begin
                        cnt_reg  <= '0;
                        filt_reg <= 1'b0;
                    end else begin
                        cnt_reg  <= cnt_next;
                        filt_reg <= filt_next;
                    end
                end

                assign filt[gi] = filt_reg;
            end

            logic filt_d_reg;
            logic rise;
            logic pending_reg;
            logic pending_next;

            // filt_d is cleared together with filt, so a line held active
            // through reset shows filt rising after release and an edge-mode
            // line registers exactly one pending event for it.
            assign rise = filt[gi] & ~filt_d_reg;

            always_comb begin
                pending_next = pending_reg;
                if (!edge_mode_i[gi]) begin
                    // Level mode: follow the filtered level, ignore ack.
                    pending_next = filt[gi];
                end else if (rise) begin
                    // Set beats a simultaneous ack; a rise while already
                    // pending changes nothing (events are not counted).
                    pending_next = 1'b1;
                end else if (int_ack_i[gi]) begin
                    pending_next = 1'b0;
                end
            end

            // Switching level -> edge keeps the current pending value until it
            // is acked; edge -> level simply resumes following filt.
            always_ff @(posedge cpu_clk_50M) begin
                if (!cpu_rst_n) begin
                    filt_d_reg  <= 1'b0;
                    pending_reg <= 1'b0;
                end else begin
                    filt_d_reg  <= filt[gi];
                    pending_reg <= pending_next;
                end
            end

            assign pending_vec[gi] = pending_reg;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Output vector
    // -------------------------------------------------------------------------
`ifdef TIMER_INT_MERGE_EN
    // The timer request is OR-ed in combinationally: no extra latency and no
    // acknowledge, CP0 clears it at its source.
    always_comb begin
        int_o = 6'b0;
        if (cpu_rst_n) begin
            int_o = pending_vec | {timer_int_i, 5'b0};
        end
    end
`else
    // Port kept for a uniform interface; the value is intentionally dropped.
    logic timer_unused;
    assign timer_unused = timer_int_i;

    always_comb begin
        int_o = 6'b0;
        if (cpu_rst_n) begin
            int_o = pending_vec;
        end
    end
`endif

endmodule

// File: tb/tb_int_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for int_ctrl (FILTER_CYCLES = 2, INV_MASK = 6'h10).
// A cycle-indexed history model derives the expected int_o from the behaviour
// rules; one compare process checks int_o on every falling edge, directed
// phases pin the model with hand-computed values, then a randomized phase
// exercises modes, acks, glitches, timer and resets.
// -----------------------------------------------------------------------------
module tb_int_ctrl;

    localparam int         TB_F   = 2;
    localparam logic [5:0] TB_INV = 6'h10;
    localparam int         HMAX   = 8192;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] ext_int;
    logic [5:0] edge_mode;
    logic [5:0] ack;
    logic       timer;
    logic [5:0] int_o;

    always #10 clk = ~clk;

    int_ctrl #(
        .FILTER_CYCLES(TB_F),
        .INV_MASK     (TB_INV)
    ) dut (
        .cpu_clk_50M(clk),
        .cpu_rst_n  (rst_n),
        .ext_int_i  (ext_int),
        .edge_mode_i(edge_mode),
        .int_ack_i  (ack),
        .timer_int_i(timer),
        .int_o      (int_o)
    );

    // ---------------- model: values held after clock edge n -----------------
    // s1h/s2h: the two synchroniser stages, fh: filtered level,
    // ph: pending/level output bits.
    logic [5:0] s1h [0:HMAX-1];
    logic [5:0] s2h [0:HMAX-1];
    logic [5:0] fh  [0:HMAX-1];
    logic [5:0] ph  [0:HMAX-1];
    int n;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: int_o=%h expected %h (t=%0t)", name, got, exp, $time);
    endtask

    // Directed checks also print one line per transaction.
    task automatic lit(input string name, input logic [5:0] exp);
        $display("check %-14s int_o=%h expected %h", name, int_o, exp);
        chk(name, int_o, exp);
    endtask

    task automatic model_step();
        logic [5:0] rise;
        logic       flip;
        n = n + 1;
        if (!rst_n) begin
            s1h[n] = '0; s2h[n] = '0; fh[n] = '0; ph[n] = '0;
        end else begin
            s1h[n] = ext_int ^ TB_INV;
            s2h[n] = s1h[n-1];
            // The filtered level flips when the synchronised line has held
            // the opposite value for the last TB_F cycles.
            for (int b = 0; b < 6; b++) begin
                flip = 1'b1;
                for (int k = 1; k <= TB_F; k++)
                    if (s2h[n-k][b] == fh[n-1][b]) flip = 1'b0;
                fh[n][b] = flip ? ~fh[n-1][b] : fh[n-1][b];
            end
            rise = fh[n-1] & ~fh[n-2];
            for (int b = 0; b < 6; b++) begin
                if (!edge_mode[b])  ph[n][b] = fh[n-1][b];
                else if (rise[b])   ph[n][b] = 1'b1;
                else if (ack[b])    ph[n][b] = 1'b0;
                else                ph[n][b] = ph[n-1][b];
            end
        end
    endtask

    function automatic logic [5:0] model_out();
        logic [5:0] o;
        o = rst_n ? ph[n] : 6'h00;
`ifdef TIMER_INT_MERGE_EN
        if (rst_n) o = o | {timer, 5'b0};
`endif
        return o;
    endfunction

    // The single per-cycle compare process.
    always @(negedge clk) begin
        if (n >= 5) chk("cycle_int_o", int_o, model_out());
    end

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            model_step();
            #1;
        end
    endtask

    localparam logic [5:0] IDLE = 6'h10;   // every line inactive at the pin

    initial begin
        n = 4;
        for (int i = 0; i < 5; i++) begin
            s1h[i] = '0; s2h[i] = '0; fh[i] = '0; ph[i] = '0;
        end
        rst_n = 1'b0; ext_int = 6'h2F; edge_mode = '0; ack = '0; timer = 1'b1;

        // 1: all lines active through reset, timer too -> 0 while in reset
        tick(3);
        lit("rst_hold", 6'h00);
        timer = 1'b0;
        rst_n = 1'b1;
        tick(4);
        lit("rst_e4", 6'h00);
        tick(1);
        lit("rst_e5", 6'h3F);
        ext_int = IDLE;
        tick(6);
        lit("rst_idle", 6'h00);

        // 2: level mode glitch on line 2
        ext_int = 6'h14; tick(1); ext_int = IDLE;
        tick(3); lit("glitch1_e4", 6'h00);
        tick(4); lit("glitch1_e8", 6'h00);
        ext_int = 6'h14; tick(2); ext_int = IDLE;
        tick(2); lit("pulse2_e4", 6'h00);
        tick(1); lit("pulse2_e5", 6'h04);
        tick(1); lit("pulse2_e6", 6'h04);
        tick(1); lit("pulse2_e7", 6'h00);
        tick(4);

        // 3: edge mode line 0, pending holds, ack clears
        edge_mode = 6'h01;
        ext_int = 6'h11; tick(3); ext_int = IDLE;
        tick(10); lit("edge_hold", 6'h01);
        ack = 6'h01; tick(1); ack = '0;
        lit("edge_ack", 6'h00);
        tick(4);

        // 4: edge mode line 1, rise coinciding with ack, second rise ignored
        edge_mode = 6'h02;
        ext_int = 6'h12; tick(4);
        ack = 6'h02; tick(1); ack = '0;
        lit("set_wins", 6'h02);
        ext_int = IDLE; tick(8); lit("set_hold", 6'h02);
        ext_int = 6'h12; tick(3); ext_int = IDLE;
        tick(8); lit("second_rise", 6'h02);
        ack = 6'h02; tick(1); ack = '0;
        lit("one_ack", 6'h00);
        tick(4);

        // 5: line 4 is active-low at the pin
        edge_mode = '0;
        ext_int = 6'h00; tick(4); lit("inv_e4", 6'h00);
        tick(1); lit("inv_active", 6'h10);
        ext_int = IDLE; tick(5); lit("inv_release", 6'h00);

        // 6: timer merge, combinational
        timer = 1'b1; #1;
`ifdef TIMER_INT_MERGE_EN
        lit("timer_comb", 6'h20);
        tick(1); lit("timer_edge", 6'h20);
`else
        lit("timer_comb", 6'h00);
        tick(1); lit("timer_edge", 6'h00);
`endif
        timer = 1'b0; #1;
        lit("timer_off", 6'h00);

        // randomized phase
        for (int c = 0; c < 2500; c++) begin
            tick(1);
            rst_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 5) == 0) ext_int = 6'($urandom);
            if ($urandom_range(0, 49) == 0) edge_mode = 6'($urandom);
            ack   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h00;
            timer = ($urandom_range(0, 7) == 0);
        end
        tick(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
